// File: rtl/imu_stream_pkg.sv
// Shared definitions for the IMU BRAM-to-UART streaming path: sync marker,
// streamer FSM states and the baud divisor helper.
package imu_stream_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_WAIT_RD,
    ST_BYTES,
    ST_CKSUM,
    ST_FLUSH,
    ST_FIN,
    ST_STOP,
    ST_ABORT
  } state_t;

  // Rounded clock cycles per UART bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a valid/ready byte handshake.
// tx_ready is also high in the last cycle of the stop bit, so a byte offered
// then starts its start bit immediately with no idle bit in between.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [9:0]       shreg;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;
  logic             running;
  logic             last_tick;

  assign last_tick = running && (bit_idx == 4'd9) && (clk_cnt == CNT_MAX);
  assign tx_ready  = !running || last_tick;
  assign tx        = shreg[0];

  // Load {stop, data, start} on a handshake, then shift one bit per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '1;
      bit_idx <= '0;
      clk_cnt <= '0;
      running <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      shreg   <= {1'b1, tx_data, 1'b0};
      bit_idx <= '0;
      clk_cnt <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (clk_cnt == CNT_MAX) begin
        clk_cnt <= '0;
        shreg   <= {1'b1, shreg[9:1]};
        if (bit_idx == 4'd9) begin
          running <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imu_bram_uart_streamer.sv
// Streams N_CH-word frames from a circular BRAM region out of an 8N1 UART:
// sync byte, words MSB byte first, and a trailing XOR checksum of all word bytes.
module imu_bram_uart_streamer
  import imu_stream_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int N_CH     = 6,
  parameter int BRAM_LAT = 1,
  parameter int CLK_FREQ = 125000000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active_bit,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       num_frames,
  input  logic [DATA_W-1:0] data_bram,
  output logic [ADDR_W-1:0] addr_bram,
  output logic              en_bram,
  output logic              tx_uart,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam int N_BYTES = DATA_W / 8;
  localparam int WORD_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BYTE_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_CH - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);
  localparam logic [1:0]        LAST_LAT  = 2'(BRAM_LAT - 1);

  state_t              state;
  state_t              next_state;
  logic                start_q;
  logic                start_edge;
  logic [ADDR_W-1:0]   ptr;
  logic [15:0]         frames_left;
  logic [WORD_W-1:0]   word_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [1:0]          lat_cnt;
  logic [DATA_W-1:0]   word_r;
  logic [7:0]          cks;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                tx_fire;

  assign start_edge = start & ~start_q;
  assign tx_fire    = tx_valid & tx_ready;
  assign addr_bram  = ptr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and output decode; a dropped active_bit diverts to STOP, which
  // lets the byte already handed to the transmitter finish before aborting.
  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    tx_data    = SYNC_BYTE;
    en_bram    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    aborted    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_edge && active_bit) next_state = ST_SYNC;
      end
      ST_SYNC: begin
        if (frames_left == 16'd0) begin
          next_state = ST_FIN;
        end else begin
          tx_valid = active_bit;
          tx_data  = SYNC_BYTE;
          if (tx_fire) next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        en_bram    = 1'b1;
        next_state = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (lat_cnt == LAST_LAT) next_state = ST_BYTES;
      end
      ST_BYTES: begin
        tx_valid = active_bit;
        tx_data  = word_r[DATA_W-1 -: 8];
        if (tx_fire && byte_idx == LAST_BYTE) begin
          if (word_idx != LAST_WORD)      next_state = ST_FETCH;
          else if (frames_left == 16'd1)  next_state = ST_CKSUM;
          else                            next_state = ST_SYNC;
        end
      end
      ST_CKSUM: begin
        tx_valid = active_bit;
        tx_data  = cks;
        if (tx_fire) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (tx_ready) next_state = ST_FIN;
      end
      ST_FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_STOP: begin
        if (tx_ready) next_state = ST_ABORT;
      end
      ST_ABORT: begin
        busy       = 1'b0;
        aborted    = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
    // FLUSH is excluded: every byte has been handed over, so it completes normally.
    if (!active_bit &&
        (state inside {ST_SYNC, ST_FETCH, ST_WAIT_RD, ST_BYTES, ST_CKSUM}))
      next_state = ST_STOP;
  end

  // Datapath: start edge detect, read pointer, frame/word/byte counters, checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      ptr         <= '0;
      frames_left <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      lat_cnt     <= '0;
      word_r      <= '0;
      cks         <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (start_edge && active_bit) begin
            ptr         <= start_addr;
            frames_left <= num_frames;
            word_idx    <= '0;
            byte_idx    <= '0;
            lat_cnt     <= '0;
            cks         <= '0;
          end
        end
        ST_FETCH: ptr <= ptr + 1'b1;
        ST_WAIT_RD: begin
          if (lat_cnt == LAST_LAT) begin
            word_r  <= data_bram;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_BYTES: begin
          if (tx_fire) begin
            word_r <= word_r << 8;
            cks    <= cks ^ tx_data;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              if (word_idx == LAST_WORD) begin
                word_idx    <= '0;
                frames_left <= frames_left - 1'b1;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx_uart)
  );

endmodule
